// File: rtl/light_phase_monitor.sv
// Receive-side watchdog for the R/Y/G lamp outputs of the timed light controller:
// measures each lamp phase, checks order, one-hot encoding and phase lengths.
module light_phase_monitor #(
    parameter int CNT_W   = 5,
    parameter int RED_LEN = 9,
    parameter int YEL_LEN = 5,
    parameter int GRN_LEN = 11,
    parameter int TOL     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             light_r,
    input  logic             light_y,
    input  logic             light_g,
    input  logic             clr_err,
    output logic             phase_done,
    output logic [1:0]       phase_id,
    output logic [CNT_W-1:0] phase_len,
    output logic             len_err,
    output logic             seq_err,
    output logic             code_err,
    output logic             err_sticky,
    output logic [7:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RED_EXP = CNT_W'(RED_LEN);
    localparam logic [CNT_W-1:0] YEL_EXP = CNT_W'(YEL_LEN);
    localparam logic [CNT_W-1:0] GRN_EXP = CNT_W'(GRN_LEN);
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);

    localparam logic [2:0] CODE_R = 3'b100;
    localparam logic [2:0] CODE_Y = 3'b010;
    localparam logic [2:0] CODE_G = 3'b001;

    state_t           state_q, state_d;
    logic [2:0]       cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             phase_done_q, phase_done_d;
    logic [1:0]       phase_id_q, phase_id_d;
    logic [CNT_W-1:0] phase_len_q, phase_len_d;
    logic             len_err_q, len_err_d;
    logic             seq_err_q, seq_err_d;
    logic             code_err_q, code_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       cycle_cnt_q, cycle_cnt_d;

    logic [2:0]       code;
    logic             is_dark;
    logic             is_onehot;
    logic [2:0]       succ;
    logic [1:0]       cur_id;
    logic [CNT_W-1:0] exp_len;
    logic [CNT_W-1:0] len_diff;
    logic             len_bad;
    logic             legal;

    always_comb begin
        code      = {light_r, light_y, light_g};
        is_dark   = (code == 3'b000);
        is_onehot = (code == CODE_R) || (code == CODE_Y) || (code == CODE_G);
        // R->Y->G->R is a right rotation of the one-hot code
        succ      = {cur_q[0], cur_q[2:1]};
        legal     = (code == succ);

        case (cur_q)
            CODE_R:  begin cur_id = 2'd0; exp_len = RED_EXP; end
            CODE_Y:  begin cur_id = 2'd1; exp_len = YEL_EXP; end
            CODE_G:  begin cur_id = 2'd2; exp_len = GRN_EXP; end
            default: begin cur_id = 2'd0; exp_len = '0;      end
        endcase

        len_diff = (cnt_q >= exp_len) ? (cnt_q - exp_len) : (exp_len - cnt_q);
        len_bad  = (cnt_q == CNT_MAX) || ({1'b0, len_diff} > TOL_V);

        state_d      = state_q;
        cur_d        = cur_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        phase_done_d = 1'b0;
        phase_id_d   = phase_id_q;
        phase_len_d  = phase_len_q;
        len_err_d    = 1'b0;
        seq_err_d    = 1'b0;
        code_err_d   = 1'b0;
        cycle_cnt_d  = cycle_cnt_q;

        case (state_q)
            IDLE: begin
                if (is_onehot) begin
                    cur_d   = code;
                    cnt_d   = CNT_ONE;
                    state_d = FIRST;
                end else if (!is_dark) begin
                    code_err_d = 1'b1;
                end
            end
            default: begin
                if (code == cur_q) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end else if (is_onehot) begin
                    phase_done_d = 1'b1;
                    phase_id_d   = cur_id;
                    phase_len_d  = cnt_q;
                    len_err_d    = (state_q == TRACK) && len_bad;
                    seq_err_d    = !legal;
                    cur_d        = code;
                    cnt_d        = CNT_ONE;
                    state_d      = legal ? TRACK : FIRST;
                    // armed marks a clean, checked R->Y; a clean checked G->R then closes the cycle
                    if ((state_q == TRACK) && legal && !len_bad) begin
                        if (cur_q == CODE_R) begin
                            armed_d = 1'b1;
                        end else if (cur_q == CODE_G) begin
                            armed_d = 1'b0;
                            if (armed_q) cycle_cnt_d = cycle_cnt_q + 8'd1;
                        end
                    end else begin
                        armed_d = 1'b0;
                    end
                end else if (is_dark) begin
                    seq_err_d    = 1'b1;
                    phase_done_d = 1'b1;
                    phase_id_d   = cur_id;
                    phase_len_d  = cnt_q;
                    armed_d      = 1'b0;
                    state_d      = IDLE;
                end else begin
                    code_err_d = 1'b1;
                    armed_d    = 1'b0;
                    state_d    = IDLE;
                end
            end
        endcase

        if (len_err_d || seq_err_d || code_err_d) err_sticky_d = 1'b1;
        else if (clr_err)                         err_sticky_d = 1'b0;
        else                                      err_sticky_d = err_sticky_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_q        <= 3'b000;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            phase_done_q <= 1'b0;
            phase_id_q   <= 2'd0;
            phase_len_q  <= '0;
            len_err_q    <= 1'b0;
            seq_err_q    <= 1'b0;
            code_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            cycle_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            phase_done_q <= phase_done_d;
            phase_id_q   <= phase_id_d;
            phase_len_q  <= phase_len_d;
            len_err_q    <= len_err_d;
            seq_err_q    <= seq_err_d;
            code_err_q   <= code_err_d;
            err_sticky_q <= err_sticky_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign phase_done = phase_done_q;
    assign phase_id   = phase_id_q;
    assign phase_len  = phase_len_q;
    assign len_err    = len_err_q;
    assign seq_err    = seq_err_q;
    assign code_err   = code_err_q;
    assign err_sticky = err_sticky_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_light_phase_monitor.sv
// Bench for light_phase_monitor: hand vectors, directed corner sequences and
// randomized lamp traffic checked against a run-length reference model.
module tb_light_phase_monitor;

    localparam int TOL = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       light_r = 1'b0;
    logic       light_y = 1'b0;
    logic       light_g = 1'b0;
    logic       clr_err = 1'b0;
    logic       phase_done;
    logic [1:0] phase_id;
    logic [4:0] phase_len;
    logic       len_err;
    logic       seq_err;
    logic       code_err;
    logic       err_sticky;
    logic [7:0] cycle_cnt;

    int checks = 0;
    int passes = 0;

    light_phase_monitor #(
        .CNT_W(5), .RED_LEN(9), .YEL_LEN(5), .GRN_LEN(11), .TOL(TOL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .light_r(light_r), .light_y(light_y), .light_g(light_g),
        .clr_err(clr_err),
        .phase_done(phase_done), .phase_id(phase_id), .phase_len(phase_len),
        .len_err(len_err), .seq_err(seq_err), .code_err(code_err),
        .err_sticky(err_sticky), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: lamp runs tracked as plain integers plus a list of
    // cleanly checked phase ends; R,Y,G in a row completes a cycle.
    int   exp_tab[3] = '{9, 5, 11};
    bit   m_active;
    bit   m_checked;
    int   m_color;
    int   m_run;
    int   chain[$];
    logic       e_pd, e_le, e_se, e_ce, e_st;
    logic [1:0] e_id;
    logic [4:0] e_len;
    logic [7:0] e_cc;

    int   pd_log[$];
    bit   err_seen;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    function automatic int onehot_idx(input logic [2:0] c);
        if (c == 3'b100) return 0;
        if (c == 3'b010) return 1;
        if (c == 3'b001) return 2;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_checked = 0; m_color = 0; m_run = 0;
        chain.delete();
        e_pd = 0; e_le = 0; e_se = 0; e_ce = 0; e_st = 0;
        e_id = 2'd0; e_len = 5'd0; e_cc = 8'd0;
    endtask

    task automatic model_step(input logic [2:0] c, input logic clr);
        int  idx;
        int  n;
        int  d;
        bit  legal;
        idx = onehot_idx(c);
        n = $countones(c);
        e_pd = 0; e_le = 0; e_se = 0; e_ce = 0;
        if (!m_active) begin
            if (n == 1) begin
                m_active = 1; m_checked = 0; m_color = idx; m_run = 1;
            end else if (n > 1) begin
                e_ce = 1;
            end
        end else if (idx == m_color) begin
            m_run++;
        end else if (n == 1) begin
            e_pd  = 1;
            e_id  = 2'(m_color);
            e_len = 5'((m_run > 31) ? 31 : m_run);
            d = m_run - exp_tab[m_color];
            if (d < 0) d = -d;
            e_le  = m_checked && (m_run >= 31 || d > TOL);
            legal = (idx == (m_color + 1) % 3);
            e_se  = !legal;
            if (m_checked && legal && !e_le) begin
                chain.push_back(m_color);
                if (m_color == 2 && chain.size() >= 3 && chain[$-2] == 0 && chain[$-1] == 1) begin
                    e_cc = e_cc + 8'd1;
                    chain.delete();
                end
            end else begin
                chain.delete();
            end
            m_color = idx; m_run = 1; m_checked = legal;
        end else if (n == 0) begin
            e_se = 1; e_pd = 1;
            e_id  = 2'(m_color);
            e_len = 5'((m_run > 31) ? 31 : m_run);
            m_active = 0;
            chain.delete();
        end else begin
            e_ce = 1;
            m_active = 0;
            chain.delete();
        end
        e_st = (e_le || e_se || e_ce) ? 1'b1 : (clr ? 1'b0 : e_st);
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic [2:0] c, input logic clr);
        {light_r, light_y, light_g} = c;
        clr_err = clr;
        @(posedge clk);
        #1;
        model_step(c, clr);
        if (phase_done) pd_log.push_back(int'(phase_len));
        if (len_err || seq_err || code_err) err_seen = 1;
        checks++;
        if (phase_done === e_pd && phase_id === e_id && phase_len === e_len &&
            len_err === e_le && seq_err === e_se && code_err === e_ce &&
            err_sticky === e_st && cycle_cnt === e_cc)
            passes++;
        else
            $display("[TB] FAIL model t=%0t code=%b: got pd=%b id=%0d len=%0d le=%b se=%b ce=%b st=%b cc=%0d, expected pd=%b id=%0d len=%0d le=%b se=%b ce=%b st=%b cc=%0d",
                     $time, c, phase_done, phase_id, phase_len, len_err, seq_err, code_err, err_sticky, cycle_cnt,
                     e_pd, e_id, e_len, e_le, e_se, e_ce, e_st, e_cc);
    endtask

    task automatic hold(input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(c, 1'b0);
    endtask

    task automatic do_reset();
        {light_r, light_y, light_g} = 3'b000;
        clr_err = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] code;
        logic       clr;
        logic       pd;
        logic [1:0] id;
        logic [4:0] len;
        logic       le;
        logic       se;
        logic       ce;
        logic       st;
        logic [7:0] cc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] multis[4];
        logic [2:0] code;
        int gen_color;
        int len;
        int r;
        int q;

        multis = '{3'b011, 3'b101, 3'b110, 3'b111};

        tbl[0]  = '{3'b000, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{3'b100, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{3'b100, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{3'b010, 1'b0, 1'b1, 2'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{3'b001, 1'b0, 1'b1, 2'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[5]  = '{3'b001, 1'b0, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[6]  = '{3'b000, 1'b0, 1'b1, 2'd2, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{3'b110, 1'b1, 1'b0, 2'd2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[8]  = '{3'b000, 1'b1, 1'b0, 2'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{3'b010, 1'b0, 1'b0, 2'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{3'b111, 1'b0, 1'b0, 2'd2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};

        do_reset();
        check_output("reset_phase_len", int'(phase_len), 0);
        check_output("reset_cycle_cnt", int'(cycle_cnt), 0);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(tbl[i].code, tbl[i].clr);
            checks++;
            if (phase_done === tbl[i].pd && phase_id === tbl[i].id && phase_len === tbl[i].len &&
                len_err === tbl[i].le && seq_err === tbl[i].se && code_err === tbl[i].ce &&
                err_sticky === tbl[i].st && cycle_cnt === tbl[i].cc)
                passes++;
            else
                $display("[TB] FAIL vector %0d: got pd=%b id=%0d len=%0d le=%b se=%b ce=%b st=%b cc=%0d", i,
                         phase_done, phase_id, phase_len, len_err, seq_err, code_err, err_sticky, cycle_cnt);
        end

        // Nominal traffic: two full cycles, only the second is fully checked
        do_reset();
        pd_log.delete();
        err_seen = 0;
        hold(3'b000, 3);
        hold(R, 9); hold(Y, 5); hold(G, 11);
        hold(R, 9); hold(Y, 5); hold(G, 11);
        hold(R, 9);
        check_output("nominal_pd_count", pd_log.size(), 6);
        if (pd_log.size() == 6) begin
            check_output("nominal_len0", pd_log[0], 9);
            check_output("nominal_len1", pd_log[1], 5);
            check_output("nominal_len2", pd_log[2], 11);
            check_output("nominal_len3", pd_log[3], 9);
            check_output("nominal_len4", pd_log[4], 5);
            check_output("nominal_len5", pd_log[5], 11);
        end
        check_output("nominal_err_seen", int'(err_seen), 0);
        check_output("nominal_cycle_cnt", int'(cycle_cnt), 1);

        // Short yellow after a checked red
        hold(Y, 3);
        apply_stimulus(G, 1'b0);
        check_output("short_y_done", int'(phase_done), 1);
        check_output("short_y_id", int'(phase_id), 1);
        check_output("short_y_len", int'(phase_len), 3);
        check_output("short_y_len_err", int'(len_err), 1);
        check_output("short_y_sticky", int'(err_sticky), 1);
        apply_stimulus(G, 1'b1);
        check_output("clr_sticky", int'(err_sticky), 0);

        // Illegal R->G jump, then the unchecked G ends
        hold(G, 9);
        hold(R, 9);
        apply_stimulus(G, 1'b0);
        check_output("jump_seq_err", int'(seq_err), 1);
        check_output("jump_done", int'(phase_done), 1);
        check_output("jump_id", int'(phase_id), 0);
        hold(G, 2);
        apply_stimulus(R, 1'b0);
        check_output("unchecked_g_len_err", int'(len_err), 0);
        check_output("unchecked_g_len", int'(phase_len), 3);
        check_output("jump_cycle_cnt", int'(cycle_cnt), 1);

        // Two lamps during yellow drop the monitor back to idle
        hold(R, 8);
        hold(Y, 2);
        apply_stimulus(3'b110, 1'b0);
        check_output("multi_code_err", int'(code_err), 1);
        check_output("multi_no_done", int'(phase_done), 0);
        hold(R, 9);
        hold(Y, 5);
        apply_stimulus(G, 1'b0);
        check_output("recover_y_id", int'(phase_id), 1);
        check_output("recover_y_len", int'(phase_len), 5);
        check_output("recover_y_len_err", int'(len_err), 0);
        check_output("recover_seq_err", int'(seq_err), 0);

        // Counter saturation on a long red
        hold(G, 10);
        hold(R, 40);
        apply_stimulus(Y, 1'b0);
        check_output("sat_len", int'(phase_len), 31);
        check_output("sat_len_err", int'(len_err), 1);
        check_output("sat_id", int'(phase_id), 0);

        // clr_err coinciding with a len_err pulse leaves the sticky flag set
        apply_stimulus(Y, 1'b1);
        check_output("clr_before_collide", int'(err_sticky), 0);
        hold(Y, 3);
        apply_stimulus(G, 1'b0);
        hold(G, 10);
        hold(R, 5);
        apply_stimulus(Y, 1'b1);
        check_output("collide_len_err", int'(len_err), 1);
        check_output("collide_sticky", int'(err_sticky), 1);

        // Asynchronous reset in the middle of green
        hold(Y, 4);
        apply_stimulus(G, 1'b0);
        hold(G, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_phase_done", int'(phase_done), 0);
        check_output("async_phase_id", int'(phase_id), 0);
        check_output("async_phase_len", int'(phase_len), 0);
        check_output("async_len_err", int'(len_err), 0);
        check_output("async_seq_err", int'(seq_err), 0);
        check_output("async_code_err", int'(code_err), 0);
        check_output("async_sticky", int'(err_sticky), 0);
        check_output("async_cycle_cnt", int'(cycle_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        err_seen = 0;
        hold(R, 9);
        hold(Y, 5);
        apply_stimulus(G, 1'b0);
        check_output("post_reset_y_len", int'(phase_len), 5);
        check_output("post_reset_err_seen", int'(err_seen), 0);
        check_output("post_reset_sticky", int'(err_sticky), 0);

        // Randomized traffic against the reference model
        gen_color = 2;
        for (int s = 0; s < 400; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                code = 3'b000;
                len = int'($urandom_range(1, 3));
            end else if (r < 9) begin
                code = multis[$urandom_range(0, 3)];
                len = int'($urandom_range(1, 2));
            end else begin
                if (r < 20) gen_color = int'($urandom_range(0, 2));
                else gen_color = (gen_color + 1) % 3;
                code = 3'b100 >> gen_color;
                q = int'($urandom_range(0, 9));
                if (q < 6) len = exp_tab[gen_color];
                else if (q < 9) len = exp_tab[gen_color] - 1 + int'($urandom_range(0, 2));
                else len = int'($urandom_range(1, 40));
            end
            for (int k = 0; k < len; k++)
                apply_stimulus(code, ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
